// File: rtl/bram_fifo_ctrl.sv
// Block-RAM-backed synchronous FIFO controller.
// Owns write/read pointers, occupancy count and status flags; drives the
// write side of the RAM through port B and the read side through port A.
// The RAM read is registered inside the RAM, so valid is the accepted read
// delayed by one cycle and data_out is the RAM output passed straight through.
//
// Ports:
//   clk, rst             single clock, synchronous active-high reset
//   wr, data_in          write request and data (accepted when !full)
//   rd                   read request (accepted when !empty)
//   data_out, valid      read data and its one-cycle strobe
//   empty, full, count   registered occupancy status
//   overflow, underflow  sticky rejected-request flags, cleared by rst
//   ram_addra, ram_doa   RAM port A (read) address and registered read data
//   ram_addrb, ram_dib,
//   ram_web              RAM port B (write) address, data, enable
module bram_fifo_ctrl #(
  parameter int unsigned WIDTH  = 10,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned ADDR_W = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     rd,
  output logic [WIDTH-1:0]         data_out,
  output logic                     valid,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow,
  output logic [ADDR_W-1:0]        ram_addra,
  input  logic [WIDTH-1:0]         ram_doa,
  output logic [ADDR_W-1:0]        ram_addrb,
  output logic [WIDTH-1:0]         ram_dib,
  output logic                     ram_web
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_nxt;
  logic             wr_acc_c;
  logic             rd_acc_c;

  // Acceptance uses the registered flags; reset blocks both sides.
  assign wr_acc_c = wr && !full && !rst;
  assign rd_acc_c = rd && !empty && !rst;

  // RAM ports are driven combinationally from the current pointers.
  assign ram_web   = wr_acc_c;
  assign ram_addrb = ADDR_W'(wr_ptr);
  assign ram_dib   = data_in;
  assign ram_addra = ADDR_W'(rd_ptr);
  assign data_out  = ram_doa;

  // Next occupancy; simultaneous accepted read and write cancel out.
  always_comb begin
    count_nxt = count;
    unique case ({wr_acc_c, rd_acc_c})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  // Pointers, registered flags and read strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      empty     <= 1'b1;
      full      <= 1'b0;
      valid     <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_acc_c) rd_ptr <= rd_ptr + PTR_W'(1);
      count     <= count_nxt;
      empty     <= (count_nxt == '0);
      full      <= (count_nxt == CNT_W'(DEPTH));
      valid     <= rd_acc_c;
      overflow  <= overflow  | (wr && full);
      underflow <= underflow | (rd && empty);
    end
  end

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Bench for bram_fifo_ctrl: a behavioural dual-port RAM sits behind the
// controller; written words are queued as expected read data and a monitor
// pops and compares whenever valid is seen.
module tb_bram_fifo_ctrl;

  localparam int unsigned WIDTH  = 10;
  localparam int unsigned DEPTH  = 32;
  localparam int unsigned ADDR_W = 12;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr = 1'b0;
  logic              rd = 1'b0;
  logic [WIDTH-1:0]  data_in = '0;
  logic [WIDTH-1:0]  data_out;
  logic              valid, empty, full, overflow, underflow;
  logic [5:0]        count;
  logic [ADDR_W-1:0] ram_addra, ram_addrb;
  logic [WIDTH-1:0]  ram_doa, ram_dib;
  logic              ram_web;

  bram_fifo_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .wr(wr), .data_in(data_in), .rd(rd),
    .data_out(data_out), .valid(valid), .empty(empty), .full(full),
    .count(count), .overflow(overflow), .underflow(underflow),
    .ram_addra(ram_addra), .ram_doa(ram_doa), .ram_addrb(ram_addrb),
    .ram_dib(ram_dib), .ram_web(ram_web)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: port B write, port A registered read.
  logic [WIDTH-1:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (ram_web) mem[ram_addrb] <= ram_dib;
    ram_doa <= mem[ram_addra];
  end

  int n_cmp = 0;
  int n_fail = 0;
  int n_valid = 0;
  int n_rd_exp = 0;
  logic [WIDTH-1:0] exp_q [$];

  // Model state
  int   mcount = 0;
  logic m_ovf = 1'b0;
  logic m_udf = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every valid must match the oldest outstanding written word.
  always @(negedge clk) begin
    if (valid) begin
      n_valid++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL data_out: got 0x%0h with no word expected at %0t", data_out, $time);
      end else begin
        check("data_out", int'(data_out), int'(exp_q.pop_front()));
      end
    end
  end

  // One cycle of stimulus; model predicts acceptance from its own count.
  task automatic cyc(input logic w, input logic [WIDTH-1:0] d, input logic r);
    bit wacc, racc;
    wr = w; data_in = d; rd = r;
    wacc = w && (mcount < DEPTH);
    racc = r && (mcount > 0);
    if (w && mcount == DEPTH) m_ovf = 1'b1;
    if (r && mcount == 0) m_udf = 1'b1;
    if (wacc) exp_q.push_back(d);
    if (racc) n_rd_exp++;
    mcount = mcount + int'(wacc) - int'(racc);
    @(negedge clk);
  endtask

  task automatic check_flags(input string tag);
    check({tag, ".count"}, int'(count), mcount);
    check({tag, ".empty"}, int'(empty), int'(mcount == 0));
    check({tag, ".full"}, int'(full), int'(mcount == DEPTH));
    check({tag, ".overflow"}, int'(overflow), int'(m_ovf));
    check({tag, ".underflow"}, int'(underflow), int'(m_udf));
  endtask

  task automatic idle();
    wr = 1'b0; rd = 1'b0;
  endtask

  initial begin
    // Reset
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_flags("reset");
    check("reset.valid", int'(valid), 0);

    // Fill to full, then one rejected write
    for (int i = 1; i <= 32; i++) begin
      cyc(1'b1, WIDTH'(i), 1'b0);
      check_flags("fill");
    end
    check("fill.full32", int'(full), 1);
    check("fill.count32", int'(count), 32);
    cyc(1'b1, 10'h3FF, 1'b0);
    check_flags("ovf");
    check("ovf.flag", int'(overflow), 1);

    // Drain back to back; valid on every cycle after an accepted read
    for (int i = 0; i < 32; i++) begin
      cyc(1'b0, '0, 1'b1);
      check("drain.valid", int'(valid), 1);
      check_flags("drain");
    end
    cyc(1'b0, '0, 1'b1);
    check("udf.flag", int'(underflow), 1);
    check("udf.valid", int'(valid), 0);
    check_flags("udf");

    // Streaming at count==1
    cyc(1'b1, 10'h100, 1'b0);
    for (int i = 0; i < 100; i++) begin
      cyc(1'b1, WIDTH'(10'h101 + i), 1'b1);
      check("stream.valid", int'(valid), 1);
      check("stream.count", int'(count), 1);
    end
    cyc(1'b0, '0, 1'b1);
    check_flags("stream_end");

    // Reset at count==10 with a read in flight and wr held high
    for (int i = 0; i < 10; i++) cyc(1'b1, WIDTH'(10'h200 + i), 1'b0);
    check("pre_rst.count", int'(count), 10);
    cyc(1'b0, '0, 1'b1);
    wr = 1'b1; data_in = 10'h2AA; rd = 1'b1; rst = 1'b1;
    #1;
    check("rst.ram_web", int'(ram_web), 0);
    @(negedge clk);
    rst = 1'b0; idle();
    mcount = 0; m_ovf = 1'b0; m_udf = 1'b0;
    exp_q.delete();
    check_flags("post_rst");
    check("post_rst.valid", int'(valid), 0);

    // Wrap-around: 20 in, 20 out, 20 in (pointers pass 31 -> 0..7), 20 out
    for (int i = 0; i < 20; i++) cyc(1'b1, WIDTH'(10'h040 + i), 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b0, '0, 1'b1);
    check("wrap.rd_addr", int'(ram_addra), 20);
    for (int i = 0; i < 20; i++) cyc(1'b1, WIDTH'(10'h0C0 + i), 1'b0);
    check("wrap.wr_addr", int'(ram_addrb), 8);
    check_flags("wrap_fill");
    for (int i = 0; i < 20; i++) cyc(1'b0, '0, 1'b1);
    idle();
    @(negedge clk);
    check_flags("wrap_drain");

    // Read from empty while writing 0x155
    cyc(1'b1, 10'h155, 1'b1);
    check("rw_empty.valid", int'(valid), 0);
    check_flags("rw_empty");
    cyc(1'b0, '0, 1'b1);
    check("rw_next.valid", int'(valid), 1);
    check("rw_next.data", int'(data_out), 10'h155);
    idle();
    repeat (2) @(negedge clk);

    check("valid_total", n_valid, n_rd_exp);
    check("queue_left", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
